// File: rtl/tri_bus_pkg.sv
// Shared types and helpers for the sequenced three-state bus driver.
// Imported by the arbiter and the top-level driver.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_TURN
    } state_t;

    // clog2 that never returns 0, so a one-value field still gets a bit
    function automatic int bits_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tri_bus_arbiter_driver_rr.sv
// Combinational round-robin pick: first requester at or after ptr,
// searching cyclically, returned as one-hot and as an index.
module rr_arbiter
    import tri_bus_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = bits_for(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] pick,
    output logic [IW-1:0]  idx,
    output logic           any
);

    logic [IW-1:0] cand;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = IW'((int'(ptr) + i) % NCH);
            if (!any && req[cand]) begin
                any        = 1'b1;
                pick[cand] = 1'b1;
                idx        = cand;
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter_driver.sv
// Multi-channel three-state bus driver: round-robin grant, active-low
// enable, turnaround gaps and a per-grant beat limit.
module tri_bus_arbiter_driver
    import tri_bus_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NCH     = 4,
    parameter int TURN    = 1,
    parameter int MAXHOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req,
    input  logic [NCH-1:0]           last,
    input  logic [NCH*WIDTH-1:0]     data_in,
    output logic [NCH-1:0]           gnt,
    output logic [bits_for(NCH)-1:0] owner,
    output logic                     oe_n,
    output wire logic [WIDTH-1:0]    bus,
    output logic                     busy
);

    localparam int IW        = bits_for(NCH);
    localparam int HW        = bits_for(MAXHOLD + 1);
    localparam int TW        = bits_for(TURN);
    localparam int TURN_LOAD = (TURN == 0) ? 0 : TURN - 1;

    state_t         state, state_n;
    logic [IW-1:0]  owner_n, rr_ptr, rr_ptr_n;
    logic [NCH-1:0] gnt_n;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic [TW-1:0]  turn_cnt, turn_n;
    logic           release_c;

    logic [NCH-1:0] pick_oh;
    logic [IW-1:0]  pick_idx;
    logic           pick_any;

    logic [WIDTH-1:0] lane [NCH];
    logic [WIDTH-1:0] sel_data;
    logic             sel_req, sel_last;

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        assign lane[c] = data_in[c*WIDTH +: WIDTH];
    end

    assign sel_data = lane[owner];
    assign sel_req  = req[owner];
    assign sel_last = last[owner];

    rr_arbiter #(
        .NCH (NCH),
        .IW  (IW)
    ) u_rr (
        .req  (req),
        .ptr  (rr_ptr),
        .pick (pick_oh),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // A beat is driven only while the owner keeps its request up
    assign oe_n = !((state == ST_DRIVE) && sel_req);
    assign busy = (state != ST_IDLE);

    for (genvar b = 0; b < WIDTH; b++) begin : g_buf
        assign bus[b] = oe_n ? 1'bz : sel_data[b];
    end

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        gnt_n     = gnt;
        rr_ptr_n  = rr_ptr;
        hold_n    = hold_cnt;
        turn_n    = turn_cnt;
        release_c = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_n = pick_idx;
                    gnt_n   = pick_oh;
                    hold_n  = '0;
                    state_n = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (sel_req) begin
                    hold_n    = hold_cnt + HW'(1);
                    release_c = sel_last ||
                                (hold_cnt == HW'(MAXHOLD - 1));
                end else begin
                    release_c = 1'b1;
                end
                if (release_c) begin
                    gnt_n    = '0;
                    rr_ptr_n = (owner == IW'(NCH - 1)) ?
                               '0 : owner + IW'(1);
                    if (TURN == 0) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_TURN;
                        turn_n  = TW'(TURN_LOAD);
                    end
                end
            end
            ST_TURN: begin
                if (turn_cnt == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    turn_n = turn_cnt - TW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= '0;
            gnt      <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            gnt      <= gnt_n;
            rr_ptr   <= rr_ptr_n;
            hold_cnt <= hold_n;
            turn_cnt <= turn_n;
        end
    end

endmodule

// File: tb/tb_tri_bus_arbiter_driver.sv
// Bench for tri_bus_arbiter_driver: a directed table, corner sequences
// and a random run, all against an abstract bus-ownership model.
module tb_tri_bus_arbiter_driver;

    localparam int N  = 4;
    localparam int MH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, last;
    logic [31:0] data_in;

    logic [3:0] gnt1, gnt0;
    logic [1:0] own1, own0;
    logic       oe1, oe0, busy1, busy0;
    wire  [7:0] bus1, bus0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int q1c[$], q1o[$], q0c[$], q0o[$];

    always #5 clk = ~clk;

    tri_bus_arbiter_driver #(
        .WIDTH(8), .NCH(N), .TURN(1), .MAXHOLD(MH)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .last(last),
        .data_in(data_in), .gnt(gnt1), .owner(own1),
        .oe_n(oe1), .bus(bus1), .busy(busy1)
    );

    tri_bus_arbiter_driver #(
        .WIDTH(8), .NCH(N), .TURN(0), .MAXHOLD(MH)
    ) dut_t0 (
        .clk(clk), .rst(rst), .req(req), .last(last),
        .data_in(data_in), .gnt(gnt0), .owner(own0),
        .oe_n(oe0), .bus(bus0), .busy(busy0)
    );

    // own: driving channel or -1; gap: turnaround cycles still to go
    typedef struct {
        int own;
        int gap;
        int beats;
        int ptr;
        int prev;
    } mdl_t;

    mdl_t m1, m0;

    function automatic mdl_t m_reset();
        mdl_t m;
        m.own = -1; m.gap = 0; m.beats = 0;
        m.ptr = 0;  m.prev = 0;
        return m;
    endfunction

    function automatic mdl_t m_step(mdl_t m, logic [3:0] rq,
                                    logic [3:0] ls, int turn);
        bit rel;
        rel = 1'b0;
        if (m.own >= 0) begin
            if (!rq[2'(m.own)]) begin
                rel = 1'b1;
            end else begin
                m.beats++;
                if (ls[2'(m.own)] || m.beats == MH) rel = 1'b1;
            end
            if (rel) begin
                m.ptr = (m.own + 1) % N;
                m.own = -1;
                m.gap = turn;
            end
        end else if (m.gap > 0) begin
            m.gap--;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m.ptr + k) % N;
                if (m.own < 0 && rq[2'(c)]) begin
                    m.own = c;
                    m.prev = c;
                    m.beats = 0;
                end
            end
        end
        return m;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input mdl_t m,
                             input logic [3:0] g, input logic [1:0] o,
                             input logic oe, input logic bsy,
                             input logic [7:0] bv);
        logic       drv;
        logic [3:0] eg;
        logic [7:0] eb;
        drv = (m.own >= 0) && req[2'(m.own)];
        eg  = (m.own >= 0) ? 4'(1 << m.own) : 4'b0;
        eb  = (m.own >= 0) ? 8'(data_in >> (8 * m.own)) : 8'h0;
        cmp({tag, ".gnt"}, 32'(g), 32'(eg));
        cmp({tag, ".owner"}, 32'(o), 32'(m.prev));
        cmp({tag, ".oe_n"}, 32'(oe), 32'(!drv));
        cmp({tag, ".busy"}, 32'(bsy),
            32'((m.own >= 0) || (m.gap > 0)));
        cmp({tag, ".onehot"}, 32'($countones(g) <= 1), 32'd1);
        if (drv) cmp({tag, ".bus"}, 32'(bv), 32'(eb));
    endtask

    task automatic apply(input logic r, input logic [3:0] rq,
                         input logic [3:0] ls, input logic [31:0] d);
        rst = r; req = rq; last = ls; data_in = d;
    endtask

    task automatic mid();
        @(negedge clk);
        check_dut("t1", m1, gnt1, own1, oe1, busy1, bus1);
        check_dut("t0", m0, gnt0, own0, oe0, busy0, bus0);
        if (!oe1) begin q1c.push_back(cyc); q1o.push_back(int'(own1)); end
        if (!oe0) begin q0c.push_back(cyc); q0o.push_back(int'(own0)); end
    endtask

    task automatic fin();
        @(posedge clk);
        if (rst) begin
            m1 = m_reset();
            m0 = m_reset();
        end else begin
            m1 = m_step(m1, req, last, 1);
            m0 = m_step(m0, req, last, 0);
        end
        cyc++;
        #1;
    endtask

    task automatic clear_q();
        q1c.delete(); q1o.delete(); q0c.delete(); q0o.delete();
    endtask

    task automatic run(input logic [3:0] rq, input logic [3:0] ls,
                       input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, rq, ls, $urandom);
            mid();
            fin();
        end
    endtask

    task automatic do_reset();
        apply(1'b1, 4'h0, 4'h0, 32'h0);
        mid();
        fin();
        clear_q();
    endtask

    task automatic chk_order(input string nm, input int qc[$],
                             input int qo[$], input int n,
                             input int md, input int gap);
        cmp({nm, ".beats"}, 32'(qc.size() >= n), 32'd1);
        if (qc.size() >= n) begin
            for (int i = 0; i < n; i++) begin
                cmp($sformatf("%s.own%0d", nm, i), 32'(qo[i]),
                    32'(i % md));
                if (i > 0)
                    cmp($sformatf("%s.gap%0d", nm, i),
                        32'(qc[i] - qc[i-1]), 32'(gap));
            end
        end
    endtask

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic [3:0] ls;
        logic [7:0] l1;
        logic [3:0] g;
        logic [1:0] o;
        logic       oe;
        logic       bsy;
        logic [7:0] bv;
    } vec_t;

    localparam int NT = 13;
    vec_t tab [NT];

    initial begin
        tab[0]  = '{1'b0, 4'b0010, 4'b0000, 8'hA0, 4'b0000, 2'd0, 1'b1, 1'b0, 8'h00};
        tab[1]  = '{1'b0, 4'b0010, 4'b0000, 8'hA1, 4'b0010, 2'd1, 1'b0, 1'b1, 8'hA1};
        tab[2]  = '{1'b0, 4'b0010, 4'b0000, 8'hA2, 4'b0010, 2'd1, 1'b0, 1'b1, 8'hA2};
        tab[3]  = '{1'b0, 4'b0010, 4'b0010, 8'hA3, 4'b0010, 2'd1, 1'b0, 1'b1, 8'hA3};
        tab[4]  = '{1'b0, 4'b0000, 4'b0000, 8'hA4, 4'b0000, 2'd1, 1'b1, 1'b1, 8'h00};
        tab[5]  = '{1'b0, 4'b0000, 4'b0000, 8'hA5, 4'b0000, 2'd1, 1'b1, 1'b0, 8'h00};
        tab[6]  = '{1'b0, 4'b0100, 4'b0000, 8'h00, 4'b0000, 2'd1, 1'b1, 1'b0, 8'h00};
        tab[7]  = '{1'b1, 4'b0100, 4'b0000, 8'h00, 4'b0100, 2'd2, 1'b0, 1'b1, 8'h2B};
        tab[8]  = '{1'b0, 4'b1111, 4'b0000, 8'h00, 4'b0000, 2'd0, 1'b1, 1'b0, 8'h00};
        tab[9]  = '{1'b0, 4'b1111, 4'b0000, 8'h00, 4'b0001, 2'd0, 1'b0, 1'b1, 8'h1A};
        tab[10] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0001, 2'd0, 1'b1, 1'b1, 8'h00};
        tab[11] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 2'd0, 1'b1, 1'b1, 8'h00};
        tab[12] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 2'd0, 1'b1, 1'b0, 8'h00};

        apply(1'b1, 4'h0, 4'h0, 32'h0);
        @(posedge clk);
        m1 = m_reset();
        m0 = m_reset();
        #1;

        // single burst, reset mid-drive, drop after one beat
        for (int i = 0; i < NT; i++) begin
            apply(tab[i].r, tab[i].rq, tab[i].ls,
                  {8'h3C, 8'h2B, tab[i].l1, 8'h1A});
            mid();
            cmp($sformatf("tab%0d.gnt", i), 32'(gnt1), 32'(tab[i].g));
            cmp($sformatf("tab%0d.owner", i), 32'(own1), 32'(tab[i].o));
            cmp($sformatf("tab%0d.oe_n", i), 32'(oe1), 32'(tab[i].oe));
            cmp($sformatf("tab%0d.busy", i), 32'(busy1), 32'(tab[i].bsy));
            if (!tab[i].oe)
                cmp($sformatf("tab%0d.bus", i), 32'(bus1), 32'(tab[i].bv));
            fin();
        end

        do_reset();
        run(4'b1111, 4'b1111, 20);
        chk_order("rr1", q1c, q1o, 5, 4, 3);
        chk_order("rr0", q0c, q0o, 5, 4, 2);

        do_reset();
        run(4'b1000, 4'b0000, 14);
        cmp("pre.n", 32'(q1c.size() >= 5), 32'd1);
        if (q1c.size() >= 5) begin
            cmp("pre.burst", 32'(q1c[3] - q1c[0]), 32'd3);
            cmp("pre.gap", 32'(q1c[4] - q1c[3]), 32'd3);
            cmp("pre.regrant", 32'(q1o[4]), 32'd3);
        end

        do_reset();
        run(4'b0001, 4'b0000, 3);
        apply(1'b0, 4'b0000, 4'b0000, $urandom);
        mid();
        cmp("drop.oe_n", 32'(oe1), 32'd1);
        cmp("drop.busy", 32'(busy1), 32'd1);
        fin();
        clear_q();
        run(4'b0011, 4'b0000, 4);
        cmp("drop.n", 32'(q1o.size() > 0 && q0o.size() > 0), 32'd1);
        if (q1o.size() > 0) cmp("drop.next1", 32'(q1o[0]), 32'd1);
        if (q0o.size() > 0) cmp("drop.next0", 32'(q0o[0]), 32'd1);

        do_reset();
        run(4'b0011, 4'b0011, 12);
        chk_order("alt0", q0c, q0o, 5, 2, 2);

        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 63) == 0, 4'($urandom),
                  4'($urandom) & 4'($urandom), $urandom);
            mid();
            fin();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
